cmos_nvram_arbiter: RTL

//  Owns the 1Kx4 battery-backed CMOS RAM (high scores, settings) of the Williams-2 core.

---
 rtl/cmos_nvram_pkg.sv | 14 +
 rtl/nvram_sp.sv | 25 ++
 rtl/cmos_nvram_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cmos_nvram_pkg.sv
// Shared types and default geometry for the Williams-2 CMOS NVRAM arbiter.
package cmos_nvram_pkg;

  localparam int NV_ADDR_W = 10;
  localparam int NV_DATA_W = 4;
  localparam int NV_HPS_W  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HPS_ACK = 2'd1,
    INIT    = 2'd2
  } nv_state_t;

endpackage

// File: rtl/nvram_sp.sv
// Single-port synchronous RAM with a registered read; contents are never reset.
module nvram_sp #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_din;
    end
    r_q <= r_mem[i_addr];
  end

  assign o_q = r_q;

endmodule

// File: rtl/cmos_nvram_arbiter.sv
// Owns the battery-backed CMOS RAM: CPU has zero-wait priority, HPS gets bounded-starvation
// slots, and a clear request fills the whole array with INIT_VALUE.
module cmos_nvram_arbiter
  import cmos_nvram_pkg::*;
#(
  parameter int              ADDR_W     = NV_ADDR_W,
  parameter int              DATA_W     = NV_DATA_W,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0,
  parameter int              STARVE_MAX = 8
) (
  input  logic              i_clk_sys,
  input  logic              i_reset,
  input  logic              i_cpu_cs,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_din,
  output logic [DATA_W-1:0] o_cpu_dout,
  output logic              o_cpu_wait,
  input  logic              i_hps_req,
  input  logic              i_hps_we,
  input  logic [ADDR_W-1:0] i_hps_addr,
  input  logic [7:0]        i_hps_din,
  output logic [7:0]        o_hps_dout,
  output logic              o_hps_ack,
  input  logic              i_nv_clear,
  output logic              o_init_busy,
  output logic              o_dirty,
  input  logic              i_hps_clear_dirty
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  nv_state_t         r_state;
  logic [DATA_W-1:0] r_cpu_dout;
  logic [7:0]        r_hps_dout;
  logic              r_cpu_wait;
  logic              r_hps_ack;
  logic              r_init_busy;
  logic              r_dirty;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_clear_pend;
  logic [ADDR_W-1:0] r_init_addr;
  logic              r_cpu_rd_pend;
  logic              r_hps_rd;

  logic              w_cpu_acc;
  logic              w_cpu_wr;
  logic              w_clear_go;
  logic              w_hps_grant;
  logic              w_hps_deny;
  logic              w_init_last;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_din;
  logic [DATA_W-1:0] w_q;

  generate
    if (DATA_W < 8) begin : g_hps_din_unused
      logic w_unused_hps_din;
      assign w_unused_hps_din = ^i_hps_din[7:DATA_W];
    end
  endgenerate

  // cpu_wait is the only thing that steals the port from the CPU (INIT or a forced HPS slot).
  assign w_cpu_acc   = i_cpu_cs && !r_cpu_wait;
  assign w_cpu_wr    = w_cpu_acc && i_cpu_we;
  assign w_clear_go  = (r_state == IDLE) && (i_nv_clear || r_clear_pend);
  assign w_hps_grant = (r_state == IDLE) && i_hps_req && (!i_cpu_cs || r_cpu_wait) && !w_clear_go;
  assign w_hps_deny  = (r_state == IDLE) && i_hps_req && i_cpu_cs && !r_cpu_wait && !w_clear_go;
  assign w_init_last = &r_init_addr;

  always_comb begin
    w_ram_we   = 1'b0;
    w_ram_addr = i_cpu_addr;
    w_ram_din  = i_cpu_din;
    if (r_state == INIT) begin
      w_ram_we   = 1'b1;
      w_ram_addr = r_init_addr;
      w_ram_din  = INIT_VALUE;
    end else if (w_cpu_acc) begin
      w_ram_we   = i_cpu_we;
    end else if (w_hps_grant) begin
      w_ram_we   = i_hps_we;
      w_ram_addr = i_hps_addr;
      w_ram_din  = i_hps_din[DATA_W-1:0];
    end
  end

  nvram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .i_clk  (i_clk_sys),
    .i_we   (w_ram_we),
    .i_addr (w_ram_addr),
    .i_din  (w_ram_din),
    .o_q    (w_q)
  );

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_cpu_dout    <= '0;
      r_hps_dout    <= '0;
      r_cpu_wait    <= 1'b0;
      r_hps_ack     <= 1'b0;
      r_init_busy   <= 1'b0;
      r_dirty       <= 1'b0;
      r_starve_cnt  <= '0;
      r_clear_pend  <= 1'b0;
      r_init_addr   <= '0;
      r_cpu_rd_pend <= 1'b0;
      r_hps_rd      <= 1'b0;
    end else begin
      r_cpu_rd_pend <= w_cpu_acc && !i_cpu_we;
      if (r_cpu_rd_pend) begin
        r_cpu_dout <= w_q;
      end

      if (w_cpu_wr) begin
        r_dirty <= 1'b1;
      end else if (i_hps_clear_dirty) begin
        r_dirty <= 1'b0;
      end

      if (w_hps_grant) begin
        r_starve_cnt <= '0;
      end else if (w_hps_deny && (r_starve_cnt != CNT_W'(STARVE_MAX))) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end

      r_hps_ack  <= 1'b0;
      r_cpu_wait <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_clear_go) begin
            r_state      <= INIT;
            r_clear_pend <= 1'b0;
            r_init_addr  <= '0;
            r_init_busy  <= 1'b1;
            r_cpu_wait   <= 1'b1;
          end else if (w_hps_grant) begin
            r_state   <= HPS_ACK;
            r_hps_ack <= 1'b1;
            r_hps_rd  <= !i_hps_we;
          end else if (w_hps_deny && (r_starve_cnt >= CNT_W'(STARVE_MAX - 1))) begin
            r_cpu_wait <= 1'b1;
          end
        end
        HPS_ACK: begin
          if (r_hps_rd) begin
            r_hps_dout <= 8'(w_q);
          end
          if (i_nv_clear) begin
            r_clear_pend <= 1'b1;
          end
          r_state <= IDLE;
        end
        INIT: begin
          if (w_init_last) begin
            r_state     <= IDLE;
            r_init_busy <= 1'b0;
            r_dirty     <= 1'b1;
          end else begin
            r_init_addr <= r_init_addr + ADDR_W'(1);
            r_cpu_wait  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM read data arrives one cycle after the access; show it live, then hold it.
  assign o_cpu_dout  = r_cpu_rd_pend ? w_q : r_cpu_dout;
  assign o_hps_dout  = ((r_state == HPS_ACK) && r_hps_rd) ? 8'(w_q) : r_hps_dout;
  assign o_cpu_wait  = r_cpu_wait;
  assign o_hps_ack   = r_hps_ack;
  assign o_init_busy = r_init_busy;
  assign o_dirty     = r_dirty;

endmodule
